// File: rtl/bp_pkg.sv
// Shared definitions for the PHT arbiter: FSM encoding, counter reset value,
// PC-to-index mapping and the 2-bit saturating counter update.
package bp_pkg;

  localparam logic [1:0] PHT_WEAK_NT = 2'b01;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_UPD_RD = 2'd2,
    ST_UPD_WR = 2'd3
  } pht_state_e;

  // Instructions are word aligned, so the index starts at pc[2].
  function automatic logic [63:0] pht_idx(input logic [63:0] pc, input int unsigned idx_bits);
    logic [63:0] mask;
    mask = (64'd1 << idx_bits) - 64'd1;
    return (pc >> 2) & mask;
  endfunction

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != 2'b11) res = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) res = ctr - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Small FIFO buffering resolved-branch updates until the PHT port is free.
// A push while full is accepted only when a pop frees a slot the same cycle.
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  assign o_data  = r_mem[r_rd_ptr[PW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_drop  = i_push && !w_do_push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
  end

endmodule

// File: rtl/bp_pht_arbiter.sv
// Owns the single-ported PHT RAM: initialisation sweep after reset, then
// arbitration between FE lookups and queued read-modify-write updates.
module bp_pht_arbiter
  import bp_pkg::*;
#(
  parameter int DBITS      = 32,
  parameter int IDX_BITS   = 8,
  parameter int UQ_DEPTH   = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fe_req,
  input  logic [DBITS-1:0]    fe_pc,
  output logic                fe_pred_valid,
  output logic                fe_pred_hit,
  output logic                fe_pred_taken,
  input  logic                agex_upd_valid,
  input  logic [DBITS-1:0]    agex_upd_pc,
  input  logic                agex_upd_taken,
  output logic [IDX_BITS-1:0] mem_addr,
  output logic                mem_we,
  output logic [1:0]          mem_wdata,
  input  logic [1:0]          mem_rdata,
  output logic                init_done,
  output logic [15:0]         drop_cnt
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  pht_state_e          r_state;
  pht_state_e          w_state_nxt;
  logic [IDX_BITS-1:0] r_ptr;
  logic                r_init_done;
  logic [SW-1:0]       r_starve;
  logic [IDX_BITS-1:0] r_hold_idx;
  logic                r_hold_taken;
  logic                r_pred_valid;
  logic                r_pred_grant;
  logic [15:0]         r_drop_cnt;

  logic [IDX_BITS-1:0] w_fe_idx;
  logic [IDX_BITS-1:0] w_upd_idx;
  logic [IDX_BITS:0]   w_fifo_dout;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_fifo_drop;
  logic                w_upd_win;
  logic                w_pop;
  logic                w_grant;
  logic                w_we;
  logic [IDX_BITS-1:0] w_addr;
  logic [1:0]          w_wdata;

  assign w_fe_idx  = IDX_BITS'(pht_idx(64'(fe_pc), IDX_BITS));
  assign w_upd_idx = IDX_BITS'(pht_idx(64'(agex_upd_pc), IDX_BITS));

  bp_upd_fifo #(
    .WIDTH(IDX_BITS + 1),
    .DEPTH(UQ_DEPTH)
  ) u_upd_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (agex_upd_valid),
    .i_data ({w_upd_idx, agex_upd_taken}),
    .i_pop  (w_pop),
    .o_data (w_fifo_dout),
    .o_full (w_fifo_full),
    .o_empty(w_fifo_empty),
    .o_drop (w_fifo_drop)
  );

  // Updates yield to lookups unless the FE is quiet, has starved them, or the queue is full.
  assign w_upd_win = !w_fifo_empty &&
                     (!fe_req || (r_starve == STARVE_LIM) || w_fifo_full);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_grant     = 1'b0;
    w_we        = 1'b0;
    w_addr      = '0;
    w_wdata     = '0;
    case (r_state)
      ST_INIT: begin
        w_we    = 1'b1;
        w_addr  = r_ptr;
        w_wdata = PHT_WEAK_NT;
        if (r_ptr == {IDX_BITS{1'b1}}) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_upd_win) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_UPD_RD;
        end else if (fe_req) begin
          w_grant = 1'b1;
          w_addr  = w_fe_idx;
        end
      end
      ST_UPD_RD: begin
        w_addr      = r_hold_idx;
        w_state_nxt = ST_UPD_WR;
      end
      ST_UPD_WR: begin
        w_we        = 1'b1;
        w_addr      = r_hold_idx;
        w_wdata     = sat_update(mem_rdata, r_hold_taken);
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // The RAM port is forced quiet while reset is held so an in-flight write is aborted at once.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      mem_we    = w_we;
      mem_addr  = w_addr;
      mem_wdata = w_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_INIT;
      r_ptr        <= '0;
      r_init_done  <= 1'b0;
      r_starve     <= '0;
      r_hold_idx   <= '0;
      r_hold_taken <= 1'b0;
      r_pred_valid <= 1'b0;
      r_pred_grant <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pred_valid <= fe_req;
      r_pred_grant <= w_grant;
      if (r_state == ST_INIT) begin
        r_ptr <= r_ptr + 1'b1;
        if (r_ptr == {IDX_BITS{1'b1}}) r_init_done <= 1'b1;
      end
      if (w_pop) begin
        r_hold_idx   <= w_fifo_dout[IDX_BITS:1];
        r_hold_taken <= w_fifo_dout[0];
      end
      if (r_state == ST_UPD_RD) begin
        r_starve <= '0;
      end else if (w_grant && !w_fifo_empty && (r_starve != STARVE_LIM)) begin
        r_starve <= r_starve + 1'b1;
      end
      if (w_fifo_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign fe_pred_valid = r_pred_valid;
  assign fe_pred_hit   = r_pred_grant;
  assign fe_pred_taken = r_pred_grant & mem_rdata[1];
  assign init_done     = r_init_done;
  assign drop_cnt      = r_drop_cnt;

endmodule
